nand_stimulus_sequencer: RTL and testbench

Synthesizable upstream stimulus and check stage for the four-input NAND gate block.
- Drives the gate's a,b,c,d inputs through all 16 input vectors in binary order (a = MSB, d = LSB), holding each for a programmable number of clocks.
- Samples the gate's three outputs e,f,g on the last hold cycle of each vector.
- Compares each output against the expected value ~(a&b&c&d) and reports an error count and a pass/done status.
- Replaces the free-running toggle stimulus with a clocked, restartable on-board sequence.

---
 rtl/nand_seq_pkg.sv | 18 +
 rtl/nand_hold_timer.sv | 55 +++++
 rtl/nand_stimulus_sequencer.sv | 140 ++++++++++++++
 tb/tb_nand_stimulus_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_seq_pkg.sv
// Shared types and helpers for the NAND gate stimulus/check sequencer.
// Holds the sequencer state encoding, vector range constants and the reference NAND function.
package nand_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int         NUM_VECTORS = 16;
    localparam logic [3:0] LAST_VEC    = 4'hF;

    function automatic logic expected_nand(input logic [3:0] idx);
        return ~&idx;
    endfunction

endpackage

// File: rtl/nand_hold_timer.sv
// Per-vector hold counter and vector index; strobes on the last hold cycle of each vector.
// Latency: strobe is combinational from registered hold count; index never wraps past LAST_VEC.
module nand_hold_timer
    import nand_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       enable_i,
    output logic [3:0] index_o,
    output logic       sample_strobe_o,
    output logic       last_vec_o
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [7:0] hold_q, hold_d;
    logic [3:0] index_q, index_d;

    assign sample_strobe_o = (hold_q == HOLD_LAST);
    assign last_vec_o      = (index_q == LAST_VEC);
    assign index_o         = index_q;

    always_comb begin
        hold_d  = hold_q;
        index_d = index_q;
        if (clear_i) begin
            hold_d  = 8'd0;
            index_d = 4'd0;
        end else if (enable_i) begin
            if (sample_strobe_o) begin
                hold_d = 8'd0;
                // Park on the last vector so DONE keeps presenting 1111.
                if (!last_vec_o) begin
                    index_d = index_q + 4'd1;
                end
            end else begin
                hold_d = hold_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= 8'd0;
            index_q <= 4'd0;
        end else begin
            hold_q  <= hold_d;
            index_q <= index_d;
        end
    end

endmodule

// File: rtl/nand_stimulus_sequencer.sv
// Walks a,b,c,d through all 16 vectors, checks e,f,g against NAND, reports err_cnt/pass/done.
// Optional first-failure capture under macro FIRST_FAIL_CAPTURE_EN; start ignored while busy.
module nand_stimulus_sequencer
    import nand_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [3:0]       fail_vec,
    output logic [2:0]       fail_efg
);

    seq_state_t       state_q, state_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d, err_sat;
    logic [ERR_W:0]   err_sum;
    logic [1:0]       mism;
    logic [3:0]       index;
    logic             strobe, last_vec, tmr_clr, tmr_en, launch, exp_x;

    nand_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (tmr_clr),
        .enable_i       (tmr_en),
        .index_o        (index),
        .sample_strobe_o(strobe),
        .last_vec_o     (last_vec)
    );

    assign exp_x   = expected_nand(index);
    assign mism    = {1'b0, e ^ exp_x} + {1'b0, f ^ exp_x} + {1'b0, g ^ exp_x};
    assign err_sum = {1'b0, err_q} + (ERR_W + 1)'(mism);
    assign err_sat = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    tmr_clr = 1'b1;
                    launch  = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                end
            end
            RUN: begin
                tmr_en = 1'b1;
                if (strobe) begin
                    err_d = err_sat;
                    if (last_vec) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_sat == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    assign {a, b, c, d} = index;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_cnt      = err_q;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic       fvld_q;
    logic [3:0] fvec_q;
    logic [2:0] fefg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fvld_q <= 1'b0;
            fvec_q <= 4'd0;
            fefg_q <= 3'd0;
        end else if (launch) begin
            fvld_q <= 1'b0;
            fvec_q <= 4'd0;
            fefg_q <= 3'd0;
        end else if ((state_q == RUN) && strobe && (mism != 2'd0) && !fvld_q) begin
            fvld_q <= 1'b1;
            fvec_q <= index;
            fefg_q <= {e, f, g};
        end
    end

    assign fail_valid = fvld_q;
    assign fail_vec   = fvec_q;
    assign fail_efg   = fefg_q;
`else
    assign fail_valid = 1'b0;
    assign fail_vec   = 4'd0;
    assign fail_efg   = 3'd0;
`endif

endmodule

// File: tb/tb_nand_stimulus_sequencer.sv
// Directed bench: fault-injecting gate model on e,f,g, plus a HOLD_CYCLES=2 instance.
module tb_nand_stimulus_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, start2 = 1'b0;
    logic       e, f, g, e2, f2, g2;
    logic       a, b, c, d, a2, b2, c2, d2;
    logic       busy, done, pass, busy2, done2, pass2;
    logic [5:0] err_cnt, err_cnt2;
    logic       fail_valid, fail_valid2;
    logic [3:0] fail_vec, fail_vec2;
    logic [2:0] fail_efg, fail_efg2;
    int         fault = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    // Gate model: 0 ideal, 1 f stuck at 1, 2 all outputs stuck at 0.
    always_comb begin
        logic x;
        x = ~(a & b & c & d);
        e = (fault == 2) ? 1'b0 : x;
        f = (fault == 1) ? 1'b1 : ((fault == 2) ? 1'b0 : x);
        g = (fault == 2) ? 1'b0 : x;
    end

    assign e2 = ~(a2 & b2 & c2 & d2);
    assign f2 = e2;
    assign g2 = e2;

    nand_stimulus_sequencer #(.HOLD_CYCLES(4), .ERR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .e(e), .f(f), .g(g),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_efg(fail_efg)
    );

    nand_stimulus_sequencer #(.HOLD_CYCLES(2), .ERR_W(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .e(e2), .f(f2), .g(g2),
        .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err_cnt2), .fail_valid(fail_valid2), .fail_vec(fail_vec2), .fail_efg(fail_efg2)
    );

    // Pulses start across exactly one rising edge; returns 1 time unit after that edge.
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({a, b, c, d, busy, done, pass} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 0000000", {a, b, c, d, busy, done, pass});
        end
        n_checks++;
        if ({err_cnt, fail_valid, fail_vec, fail_efg} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_status: got err=%0d fv=%b vec=%h efg=%b want all 0",
                     err_cnt, fail_valid, fail_vec, fail_efg);
        end
        n_checks++;
        if ({a2, b2, c2, d2, busy2, done2, err_cnt2} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_dut2: got %b want 0", {a2, b2, c2, d2, busy2, done2, err_cnt2});
        end
        #4 rst_n = 1'b1;
    endtask

    task automatic test_ideal();
        logic [3:0] exp_v;
        fault = 0;
        launch();
        n_checks++;
        if ({busy, done, pass} !== 3'b100 || {a, b, c, d} !== 4'd0) begin
            n_fail++;
            $display("FAIL ideal_launch: got bdp=%b abcd=%b want 100 0000", {busy, done, pass}, {a, b, c, d});
        end
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            exp_v = (k < 64) ? 4'(k / 4) : 4'hF;
            n_checks++;
            if ({a, b, c, d} !== exp_v) begin
                n_fail++;
                $display("FAIL ideal_vec k=%0d: got %b want %b", k, {a, b, c, d}, exp_v);
            end
            n_checks++;
            if (done !== (k == 64)) begin
                n_fail++;
                $display("FAIL ideal_done k=%0d: got %b want %b", k, done, (k == 64));
            end
        end
        n_checks++;
        if ({busy, pass} !== 2'b01 || err_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL ideal_result: got busy=%b pass=%b err=%0d want 0 1 0", busy, pass, err_cnt);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a, b, c, d, done, pass} !== 6'b111111) begin
            n_fail++;
            $display("FAIL ideal_hold_done: got %b want 111111", {a, b, c, d, done, pass});
        end
    endtask

    task automatic test_f_stuck();
        fault = 1;
        launch();
        repeat (64) @(posedge clk);
        #1;
        n_checks++;
        if ({done, pass} !== 2'b10 || err_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL fstuck: got done=%b pass=%b err=%0d want 1 0 1", done, pass, err_cnt);
        end
`ifdef FIRST_FAIL_CAPTURE_EN
        n_checks++;
        if ({fail_valid, fail_vec, fail_efg} !== {1'b1, 4'hF, 3'b010}) begin
            n_fail++;
            $display("FAIL fstuck_capture: got fv=%b vec=%h efg=%b want 1 f 010", fail_valid, fail_vec, fail_efg);
        end
`else
        n_checks++;
        if ({fail_valid, fail_vec, fail_efg} !== 8'd0) begin
            n_fail++;
            $display("FAIL fstuck_capture_off: got fv=%b vec=%h efg=%b want 0", fail_valid, fail_vec, fail_efg);
        end
`endif
    endtask

    task automatic test_all_stuck0();
        fault = 2;
        launch();
        repeat (64) @(posedge clk);
        #1;
        n_checks++;
        if ({done, pass} !== 2'b10 || err_cnt !== 6'd45) begin
            n_fail++;
            $display("FAIL stuck0: got done=%b pass=%b err=%0d want 1 0 45", done, pass, err_cnt);
        end
`ifdef FIRST_FAIL_CAPTURE_EN
        n_checks++;
        if ({fail_valid, fail_vec, fail_efg} !== {1'b1, 4'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL stuck0_capture: got fv=%b vec=%h efg=%b want 1 0 000", fail_valid, fail_vec, fail_efg);
        end
`endif
    endtask

    task automatic test_start_held();
        fault = 2;
        @(negedge clk);
        start = 1'b1;
        repeat (65) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b01 || err_cnt !== 6'd45) begin
            n_fail++;
            $display("FAIL held_first_done: got busy=%b done=%b err=%0d want 0 1 45", busy, done, err_cnt);
        end
        @(posedge clk);
        #1 start = 1'b0;
        n_checks++;
        if ({busy, done, pass} !== 3'b100 || err_cnt !== 6'd0 || {a, b, c, d} !== 4'd0) begin
            n_fail++;
            $display("FAIL held_restart: got bdp=%b err=%0d abcd=%b want 100 0 0000",
                     {busy, done, pass}, err_cnt, {a, b, c, d});
        end
        repeat (64) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b01 || err_cnt !== 6'd45) begin
            n_fail++;
            $display("FAIL held_second_done: got busy=%b done=%b err=%0d want 0 1 45", busy, done, err_cnt);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL held_stays_done: got %b want 1", done);
        end
    endtask

    task automatic test_async_reset();
        fault = 0;
        launch();
        repeat (29) @(posedge clk);
        #1;
        n_checks++;
        if ({a, b, c, d} !== 4'd7 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got abcd=%b busy=%b want 0111 1", {a, b, c, d}, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a, b, c, d, busy, done, pass} !== 7'd0 || err_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL arst_now: got %b err=%0d want 0000000 0", {a, b, c, d, busy, done, pass}, err_cnt);
        end
        #2 rst_n = 1'b1;
        launch();
        repeat (64) @(posedge clk);
        #1;
        n_checks++;
        if ({done, pass} !== 2'b11 || err_cnt !== 6'd0 || {a, b, c, d} !== 4'hF) begin
            n_fail++;
            $display("FAIL arst_rerun: got done=%b pass=%b err=%0d abcd=%b want 1 1 0 1111",
                     done, pass, err_cnt, {a, b, c, d});
        end
    endtask

    task automatic test_hold2();
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        n_checks++;
        if (done2 !== 1'b0 || {a2, b2, c2, d2} !== 4'hF) begin
            n_fail++;
            $display("FAIL hold2_early: got done=%b abcd=%b want 0 1111", done2, {a2, b2, c2, d2});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({done2, pass2, busy2} !== 3'b110 || err_cnt2 !== 6'd0) begin
            n_fail++;
            $display("FAIL hold2_done: got dpb=%b err=%0d want 110 0", {done2, pass2, busy2}, err_cnt2);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_f_stuck();
        test_all_stuck0();
        test_start_held();
        test_async_reset();
        test_hold2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
